// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds issued ALU/branch/jump ops until both operands
// are valid, then dispatches one per cycle and broadcasts the result.
module alu_reservation_station #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        op_in,
   input  logic [31:0]       value1_in,
   input  logic [31:0]       value2_in,
   input  logic [TAG_W-1:0]  query1_in,
   input  logic [TAG_W-1:0]  query2_in,
   input  logic [TAG_W-1:0]  target_in,
   input  logic [TAG_W-1:0]  mem_num,
   input  logic [31:0]       mem_value,
   output logic              rs_full,
   output logic [TAG_W-1:0]  alu_num,
   output logic [31:0]       alu_value,
   output logic              overflow
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [4:0] {
      OP_ADD   = 5'b00000,
      OP_AND   = 5'b00001,
      OP_OR    = 5'b00010,
      OP_SLL   = 5'b00011,
      OP_SRL   = 5'b00100,
      OP_SLT   = 5'b00101,
      OP_SLTU  = 5'b00110,
      OP_SRA   = 5'b00111,
      OP_SUB   = 5'b01000,
      OP_XOR   = 5'b01001,
      OP_BEQ   = 5'b01010,
      OP_BGE   = 5'b01011,
      OP_BNE   = 5'b01100,
      OP_BGEU  = 5'b01101,
      OP_JAL   = 5'b10000,
      OP_JALR  = 5'b10001,
      OP_BLT   = 5'b11010,
      OP_BLTU  = 5'b11011,
      OP_JAL_C = 5'b11100
   } op_e;

   logic [DEPTH-1:0] ent_valid;
   op_e              ent_op  [DEPTH];
   logic [31:0]      ent_v1  [DEPTH];
   logic [31:0]      ent_v2  [DEPTH];
   logic [TAG_W-1:0] ent_q1  [DEPTH];
   logic [TAG_W-1:0] ent_q2  [DEPTH];
   logic [TAG_W-1:0] ent_tgt [DEPTH];

   function automatic logic in_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SLT, OP_SLTU, OP_SRA,
         OP_SUB, OP_XOR, OP_BEQ, OP_BGE, OP_BNE, OP_BGEU, OP_JAL, OP_JALR,
         OP_BLT, OP_BLTU, OP_JAL_C: in_class = 1'b1;
         default:                   in_class = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] alu_calc(input op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] s;
      s = a + b;
      case (op)
         OP_ADD:   alu_calc = s;
         OP_SUB:   alu_calc = a - b;
         OP_AND:   alu_calc = a & b;
         OP_OR:    alu_calc = a | b;
         OP_XOR:   alu_calc = a ^ b;
         OP_SLL:   alu_calc = a << b[4:0];
         OP_SRL:   alu_calc = a >> b[4:0];
         OP_SRA:   alu_calc = $unsigned($signed(a) >>> b[4:0]);
         OP_SLT:   alu_calc = {31'b0, $signed(a) < $signed(b)};
         OP_SLTU:  alu_calc = {31'b0, a < b};
         OP_BEQ:   alu_calc = {31'b0, a == b};
         OP_BNE:   alu_calc = {31'b0, a != b};
         OP_BLT:   alu_calc = {31'b0, $signed(a) < $signed(b)};
         OP_BGE:   alu_calc = {31'b0, $signed(a) >= $signed(b)};
         OP_BLTU:  alu_calc = {31'b0, a < b};
         OP_BGEU:  alu_calc = {31'b0, a >= b};
         OP_JALR:  alu_calc = s & 32'hFFFF_FFFE;
         OP_JAL,
         OP_JAL_C: alu_calc = b;
         default:  alu_calc = '0;
      endcase
   endfunction

   logic [DEPTH-1:0] ready;
   logic             have_sel;
   logic [IDX_W-1:0] sel;
   logic             have_free;
   logic [IDX_W-1:0] free_idx;
   logic             issue_ok;
   logic             accept;
   logic             drop;
   logic [31:0]      in_v1;
   logic [31:0]      in_v2;
   logic [TAG_W-1:0] in_q1;
   logic [TAG_W-1:0] in_q2;
   logic [31:0]      disp_value;
   logic             rs_full_d;
   int unsigned      occ;

   always_comb begin
      ready     = '0;
      have_sel  = 1'b0;
      sel       = '0;
      have_free = 1'b0;
      free_idx  = '0;
      occ       = 0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ready[i] = ent_valid[i] && (ent_q1[i] == '0) && (ent_q2[i] == '0);
         if (ready[i] && !have_sel) begin
            have_sel = 1'b1;
            sel      = IDX_W'(i);
         end
         if (!ent_valid[i] && !have_free) begin
            have_free = 1'b1;
            free_idx  = IDX_W'(i);
         end
         if (ent_valid[i]) occ++;
      end

      issue_ok = in_class(op_in) && (target_in != '0);
      accept   = issue_ok && have_free;
      drop     = issue_ok && !have_free;

      // Bypass: an incoming operand tag matching a live broadcast takes its value now
      in_v1 = value1_in;
      in_q1 = query1_in;
      if (query1_in != '0 && query1_in == alu_num) begin
         in_v1 = alu_value;
         in_q1 = '0;
      end else if (query1_in != '0 && query1_in == mem_num) begin
         in_v1 = mem_value;
         in_q1 = '0;
      end
      in_v2 = value2_in;
      in_q2 = query2_in;
      if (query2_in != '0 && query2_in == alu_num) begin
         in_v2 = alu_value;
         in_q2 = '0;
      end else if (query2_in != '0 && query2_in == mem_num) begin
         in_v2 = mem_value;
         in_q2 = '0;
      end

      disp_value = alu_calc(ent_op[sel], ent_v1[sel], ent_v2[sel]);

      if (accept)   occ++;
      if (have_sel) occ--;
      rs_full_d = (occ >= DEPTH - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_op[i]  <= OP_ADD;
            ent_v1[i]  <= '0;
            ent_v2[i]  <= '0;
            ent_q1[i]  <= '0;
            ent_q2[i]  <= '0;
            ent_tgt[i] <= '0;
         end
         alu_num   <= '0;
         alu_value <= '0;
         rs_full   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
               if (ent_q1[i] != '0 && ent_q1[i] == alu_num) begin
                  ent_v1[i] <= alu_value;
                  ent_q1[i] <= '0;
               end else if (ent_q1[i] != '0 && ent_q1[i] == mem_num) begin
                  ent_v1[i] <= mem_value;
                  ent_q1[i] <= '0;
               end
               if (ent_q2[i] != '0 && ent_q2[i] == alu_num) begin
                  ent_v2[i] <= alu_value;
                  ent_q2[i] <= '0;
               end else if (ent_q2[i] != '0 && ent_q2[i] == mem_num) begin
                  ent_v2[i] <= mem_value;
                  ent_q2[i] <= '0;
               end
               if (have_sel && sel == IDX_W'(i)) ent_valid[i] <= 1'b0;
            end else if (accept && free_idx == IDX_W'(i)) begin
               ent_valid[i] <= 1'b1;
               ent_op[i]    <= op_e'(op_in);
               ent_v1[i]    <= in_v1;
               ent_v2[i]    <= in_v2;
               ent_q1[i]    <= in_q1;
               ent_q2[i]    <= in_q2;
               ent_tgt[i]   <= target_in;
            end
         end

         if (have_sel) begin
            alu_num   <= ent_tgt[sel];
            alu_value <= disp_value;
         end else begin
            alu_num   <= '0;
         end

         rs_full <= rs_full_d;
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected broadcasts are queued at
// issue time and a negedge monitor checks every nonzero alu_num in order.
module tb_alu_reservation_station;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  op_in;
   logic [31:0] value1_in;
   logic [31:0] value2_in;
   logic [2:0]  query1_in;
   logic [2:0]  query2_in;
   logic [2:0]  target_in;
   logic [2:0]  mem_num;
   logic [31:0] mem_value;
   logic        rs_full;
   logic [2:0]  alu_num;
   logic [31:0] alu_value;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  num;
      logic [31:0] val;
   } exp_t;
   exp_t sbq[$];

   alu_reservation_station #(.DEPTH(4), .TAG_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_in     (op_in),
      .value1_in (value1_in),
      .value2_in (value2_in),
      .query1_in (query1_in),
      .query2_in (query2_in),
      .target_in (target_in),
      .mem_num   (mem_num),
      .mem_value (mem_value),
      .rs_full   (rs_full),
      .alu_num   (alu_num),
      .alu_value (alu_value),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_bc(input logic [2:0] num, input logic [31:0] val);
      exp_t e;
      e.num = num;
      e.val = val;
      sbq.push_back(e);
   endtask

   // Called at a negedge; drives one issue cycle and returns at the following negedge
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tgt);
      op_in     = op;
      value1_in = a;
      value2_in = b;
      query1_in = q1;
      query2_in = q2;
      target_in = tgt;
      @(negedge clk);
      op_in     = 5'b11111;
      query1_in = '0;
      query2_in = '0;
      target_in = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && alu_num != '0) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bcast: got tag %0d value 0x%0h, expected no broadcast",
                        alu_num, alu_value);
            end else begin
               e = sbq.pop_front();
               chk("bcast_tag", {29'b0, alu_num}, {29'b0, e.num});
               chk("bcast_value", alu_value, e.val);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish by 100000, expected earlier finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      op_in = 5'b11111;
      value1_in = '0;
      value2_in = '0;
      query1_in = '0;
      query2_in = '0;
      target_in = '0;
      mem_num = '0;
      mem_value = '0;
      #1;
      chk("reset_alu_num", {29'b0, alu_num}, 32'd0);
      chk("reset_alu_value", alu_value, 32'd0);
      chk("reset_rs_full", {31'b0, rs_full}, 32'd0);
      chk("reset_overflow", {31'b0, overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Independent ADD, then broadcast goes idle
      expect_bc(3'd3, 32'd12);
      issue(5'b00000, 32'd5, 32'd7, 3'd0, 3'd0, 3'd3);
      idle(2);
      chk("idle_after_add", {29'b0, alu_num}, 32'd0);

      // Dependent chain via self-wakeup
      expect_bc(3'd2, 32'd6);
      expect_bc(3'd4, 32'd48);
      issue(5'b01000, 32'd10, 32'd4, 3'd0, 3'd0, 3'd2);
      issue(5'b00011, 32'd0, 32'd3, 3'd2, 3'd0, 3'd4);
      idle(6);

      // Memory broadcast bypass on the issue cycle
      expect_bc(3'd5, 32'd101);
      mem_num = 3'd6;
      mem_value = 32'd100;
      issue(5'b00000, 32'd1, 32'd0, 3'd0, 3'd6, 3'd5);
      mem_num = '0;
      mem_value = '0;
      idle(4);

      // Branches, JALR, shifts and misc ops, plus ignored encodings
      expect_bc(3'd1, 32'd1);
      expect_bc(3'd2, 32'd0);
      expect_bc(3'd3, 32'h0000_1002);
      expect_bc(3'd6, 32'hF800_0000);
      expect_bc(3'd7, 32'd1);
      expect_bc(3'd1, 32'd1);
      expect_bc(3'd2, 32'd0);
      expect_bc(3'd4, 32'h0000_0ABC);
      expect_bc(3'd5, 32'h0000_FF00);
      issue(5'b11010, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 3'd1);
      issue(5'b11011, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 3'd2);
      issue(5'b10001, 32'h0000_1001, 32'd2, 3'd0, 3'd0, 3'd3);
      issue(5'b00111, 32'h8000_0000, 32'd4, 3'd0, 3'd0, 3'd6);
      issue(5'b00110, 32'd3, 32'd5, 3'd0, 3'd0, 3'd7);
      issue(5'b01011, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 3'd0, 3'd0, 3'd1);
      issue(5'b01100, 32'd4, 32'd4, 3'd0, 3'd0, 3'd2);
      issue(5'b11100, 32'd9, 32'h0000_0ABC, 3'd0, 3'd0, 3'd4);
      issue(5'b01001, 32'h0000_F0F0, 32'h0000_0FF0, 3'd0, 3'd0, 3'd5);
      issue(5'b01110, 32'd1, 32'd1, 3'd0, 3'd0, 3'd3);
      issue(5'b11111, 32'd1, 32'd1, 3'd0, 3'd0, 3'd3);
      issue(5'b00000, 32'd1, 32'd1, 3'd0, 3'd0, 3'd0);
      idle(8);

      // Fill, rs_full, overflow, then mem wakeup drains in index order
      chk("rs_full_empty", {31'b0, rs_full}, 32'd0);
      issue(5'b00000, 32'd0, 32'd1, 3'd7, 3'd0, 3'd1);
      issue(5'b01000, 32'd0, 32'd8, 3'd7, 3'd0, 3'd2);
      chk("rs_full_two", {31'b0, rs_full}, 32'd0);
      issue(5'b01001, 32'd0, 32'h0000_00FF, 3'd7, 3'd0, 3'd3);
      chk("rs_full_three", {31'b0, rs_full}, 32'd1);
      chk("overflow_clear", {31'b0, overflow}, 32'd0);
      issue(5'b00010, 32'd0, 32'h0000_0100, 3'd7, 3'd0, 3'd4);
      issue(5'b00000, 32'd5, 32'd5, 3'd0, 3'd0, 3'd5);
      chk("overflow_set", {31'b0, overflow}, 32'd1);
      expect_bc(3'd1, 32'd51);
      expect_bc(3'd2, 32'd42);
      expect_bc(3'd3, 32'h0000_00CD);
      expect_bc(3'd4, 32'h0000_0132);
      mem_num = 3'd7;
      mem_value = 32'd50;
      @(negedge clk);
      mem_num = '0;
      mem_value = '0;
      chk("rs_full_held", {31'b0, rs_full}, 32'd1);
      idle(8);
      chk("rs_full_drained", {31'b0, rs_full}, 32'd0);
      chk("overflow_sticky", {31'b0, overflow}, 32'd1);

      // Asynchronous reset mid-cycle discards waiting entries
      issue(5'b00000, 32'd0, 32'd1, 3'd7, 3'd0, 3'd1);
      issue(5'b00000, 32'd0, 32'd2, 3'd7, 3'd0, 3'd2);
      issue(5'b00000, 32'd0, 32'd3, 3'd7, 3'd0, 3'd3);
      chk("rs_full_refill", {31'b0, rs_full}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_rs_full", {31'b0, rs_full}, 32'd0);
      chk("async_rst_overflow", {31'b0, overflow}, 32'd0);
      chk("async_rst_alu_num", {29'b0, alu_num}, 32'd0);
      chk("async_rst_alu_value", alu_value, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_num = 3'd7;
      mem_value = 32'd77;
      @(negedge clk);
      mem_num = '0;
      mem_value = '0;
      idle(6);

      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
